// File: rtl/vc_arbiter.sv
// vc_arbiter: moves words from two virtual-channel FIFOs (VC0, VC1) to two
// destination FIFOs (D0, D1). One pop per cycle at most; the popped word is
// routed one cycle later (VC FIFOs have registered read data) to D0 or D1
// according to bit DEST_BIT of the word. Either destination almost-full flag
// blocks pops, since the destination is unknown until the word is read.
// Start-up is sequenced by an INIT/IDLE/ACTIVE state machine.
//
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating grants when
// both VCs hold data; otherwise VC0 has strict priority over VC1.
module vc_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  d0_almost_full,
  input  logic                  d1_almost_full,
  output logic                  vc0_pop,
  output logic                  vc1_pop,
  output logic                  d0_push,
  output logic                  d1_push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  active,
  output logic                  idle,
  output logic [7:0]            pkt_count
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // In-flight word: popped last cycle, its data is on vcX_data this cycle.
  logic inflight_vld_reg;
  logic inflight_sel_reg;   // 0: VC0, 1: VC1

  logic [7:0] pkt_count_reg;

  logic stall;
  logic pop_ok;
  logic grant_sel;          // VC chosen this cycle (0: VC0, 1: VC1)
  logic pop_any;
  logic push_any;
  logic [DATA_WIDTH-1:0] word;

`ifdef ARB_ROUND_ROBIN_EN
  // VC granted by the most recent pop; starts at VC1 so VC0 wins first.
  logic last_grant_reg;
`endif

  // State register; reset and init=0 both land in INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    if (!init) begin
      state_next = ST_INIT;
    end else begin
      case (state_reg)
        ST_INIT: begin
          state_next = ST_IDLE;
        end
        ST_IDLE: begin
          if (!vc0_empty || !vc1_empty) begin
            state_next = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // Stay until the last popped word has been delivered.
          if (vc0_empty && vc1_empty && !inflight_vld_reg) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_INIT;
        end
      endcase
    end
  end

  // Grant selection and pop generation.
  always_comb begin
    stall  = d0_almost_full | d1_almost_full;
    pop_ok = (state_reg == ST_ACTIVE) && init && !stall;
`ifdef ARB_ROUND_ROBIN_EN
    if (!vc0_empty && !vc1_empty) begin
      grant_sel = ~last_grant_reg;
    end else begin
      grant_sel = vc0_empty;
    end
`else
    // VC1 only gets a turn when VC0 has nothing.
    grant_sel = vc0_empty;
`endif
    pop_any = pop_ok && (grant_sel ? !vc1_empty : !vc0_empty);
    vc0_pop = pop_any && !grant_sel;
    vc1_pop = pop_any && grant_sel;
  end

  // In-flight tracking: valid only for the cycle right after a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_vld_reg <= 1'b0;
      inflight_sel_reg <= 1'b0;
    end else if (pop_any) begin
      inflight_vld_reg <= 1'b1;
      inflight_sel_reg <= grant_sel;
    end else begin
      inflight_vld_reg <= 1'b0;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Grant history; init=0 restores the VC0-first starting point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else if (!init) begin
      last_grant_reg <= 1'b1;
    end else if (pop_any) begin
      last_grant_reg <= grant_sel;
    end
  end
`endif

  // Route the in-flight word to its destination by the destination bit.
  always_comb begin
    word     = '0;
    d0_push  = 1'b0;
    d1_push  = 1'b0;
    push_any = 1'b0;
    if (inflight_vld_reg) begin
      word     = inflight_sel_reg ? vc1_data : vc0_data;
      push_any = 1'b1;
      d1_push  = word[DEST_BIT];
      d0_push  = ~word[DEST_BIT];
    end
    data_out = word;
  end

  // Pushed-word counter, wraps modulo 256; init=0 clears it even if a
  // final in-flight word is being delivered in that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count_reg <= 8'd0;
    end else if (!init) begin
      pkt_count_reg <= 8'd0;
    end else if (push_any) begin
      pkt_count_reg <= pkt_count_reg + 8'd1;
    end
  end

  // Status decodes of the registered state.
  always_comb begin
    active    = (state_reg == ST_ACTIVE);
    idle      = (state_reg == ST_IDLE);
    pkt_count = pkt_count_reg;
  end

endmodule
